// File: rtl/pipe_sub32_if.sv
// Operand/result handshake bundle for pipe_sub32.
// The master drives operands and result-ready; the slave is the subtractor.
interface pipe_sub32_if #(
  parameter int W = 32
);
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_bin;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_d;
  logic         o_borrow;
  logic         o_zero;
  logic         o_neg;
  logic         o_ovf;

  modport master (
    output i_valid, i_a, i_b, i_bin, i_ready,
    input  o_ready, o_valid, o_d, o_borrow, o_zero, o_neg, o_ovf
  );

  modport slave (
    input  i_valid, i_a, i_b, i_bin, i_ready,
    output o_ready, o_valid, o_d, o_borrow, o_zero, o_neg, o_ovf
  );
endinterface

// File: rtl/pipe_sub32.sv
// Two-stage pipelined subtractor d = a - b - bin with borrow/zero/neg/overflow flags.
// Low half is resolved in stage 1; its carry feeds the high-half add in stage 2.
module pipe_sub32 #(
  parameter int W     = 32,
  parameter int SPLIT = 16
) (
  input logic         i_clk,
  input logic         i_rstn,
  pipe_sub32_if.slave bus
);

  localparam int HW = W - SPLIT;

  // Stage 1 state
  logic             s1_valid;
  logic [SPLIT-1:0] s1_d_lo;
  logic             s1_c;
  logic [HW-1:0]    s1_a_hi;
  logic [HW-1:0]    s1_b_hi;
  logic             s1_a_msb;
  logic             s1_b_msb;

  // Stage 2 state
  logic             s2_valid;
  logic [W-1:0]     s2_d;
  logic             s2_borrow;
  logic             s2_zero;
  logic             s2_neg;
  logic             s2_ovf;

  // Handshake
  logic s2_adv;
  logic s1_ready;
  logic s1_load;
  logic s2_load;

  // Datapath
  logic [SPLIT:0] lo_sum;
  logic [HW:0]    hi_sum;
  logic [W-1:0]   d_full;

  always_comb begin
    s2_adv   = ~s2_valid | bus.i_ready;
    s1_ready = ~s1_valid | s2_adv;
    s1_load  = bus.i_valid & s1_ready;
    s2_load  = s1_valid & s2_adv;
  end

  // Subtraction as a + ~b + ~bin; the carry out of the low half crosses into stage 2.
  always_comb begin
    lo_sum = {1'b0, bus.i_a[SPLIT-1:0]}
           + {1'b0, ~bus.i_b[SPLIT-1:0]}
           + {{SPLIT{1'b0}}, ~bus.i_bin};
  end

  always_comb begin
    hi_sum = {1'b0, s1_a_hi} + {1'b0, ~s1_b_hi} + {{HW{1'b0}}, s1_c};
    d_full = {hi_sum[HW-1:0], s1_d_lo};
  end

  // NOTE: datapath registers are reset too, so o_d and flags read 0 during and after reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid <= 1'b0;
      s1_d_lo  <= '0;
      s1_c     <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_d_lo  <= lo_sum[SPLIT-1:0];
        s1_c     <= lo_sum[SPLIT];
        s1_a_hi  <= bus.i_a[W-1:SPLIT];
        s1_b_hi  <= bus.i_b[W-1:SPLIT];
        s1_a_msb <= bus.i_a[W-1];
        s1_b_msb <= bus.i_b[W-1];
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Flags update only when a result enters stage 2, so they hold while o_valid is low.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s2_valid  <= 1'b0;
      s2_d      <= '0;
      s2_borrow <= 1'b0;
      s2_zero   <= 1'b0;
      s2_neg    <= 1'b0;
      s2_ovf    <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_load) begin
        s2_d      <= d_full;
        s2_borrow <= ~hi_sum[HW];
        s2_zero   <= (d_full == '0);
        s2_neg    <= d_full[W-1];
        s2_ovf    <= (s1_a_msb != s1_b_msb) && (d_full[W-1] != s1_a_msb);
      end
    end
  end

  assign bus.o_ready  = s1_ready;
  assign bus.o_valid  = s2_valid;
  assign bus.o_d      = s2_d;
  assign bus.o_borrow = s2_borrow;
  assign bus.o_zero   = s2_zero;
  assign bus.o_neg    = s2_neg;
  assign bus.o_ovf    = s2_ovf;

endmodule

// File: tb/tb_pipe_sub32.sv
// Self-checking bench for pipe_sub32: directed corner cases, backpressure, reset and
// random traffic scored against an arithmetic reference model.
module tb_pipe_sub32;

  typedef struct packed {
    logic [31:0] d;
    logic        borrow;
    logic        zero;
    logic        neg;
    logic        ovf;
  } res_t;

  logic i_clk;
  logic i_rstn;

  pipe_sub32_if #(.W(32)) bus ();

  pipe_sub32 #(.W(32), .SPLIT(16)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  res_t exp_q[$];
  logic stall_prev = 1'b0;
  res_t held;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    res_t   r;
    longint sa, sb, sd;
    r.d      = a - b - {31'b0, bin};
    r.borrow = ({1'b0, a} < ({1'b0, b} + {32'b0, bin}));
    r.zero   = (r.d == 32'h0);
    r.neg    = r.d[31];
    sa       = longint'($signed(a));
    sb       = longint'($signed(b));
    sd       = sa - sb - longint'(bin);
    r.ovf    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.d      = bus.o_d;
    r.borrow = bus.o_borrow;
    r.zero   = bus.o_zero;
    r.neg    = bus.o_neg;
    r.ovf    = bus.o_ovf;
    return r;
  endfunction

  // Scoreboard: inputs and outputs sampled mid-cycle, when both handshakes are settled.
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", bus.o_valid, 1);
        check("hold_result", observed(), held);
      end
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", bus.o_valid, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("d", bus.o_d, e.d);
          check("borrow", bus.o_borrow, e.borrow);
          check("zero", bus.o_zero, e.zero);
          check("neg", bus.o_neg, e.neg);
          check("ovf", bus.o_ovf, e.ovf);
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        exp_q.push_back(model(bus.i_a, bus.i_b, bus.i_bin));
        n_acc++;
      end
      stall_prev = bus.o_valid && !bus.i_ready;
      held       = observed();
    end
  end

  // Presents operands and returns at posedge+1 after the accept edge, i_valid still high.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin, input string tag);
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_bin   = bin;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_clk);
      if (bus.o_ready) break;
    end
    check({tag, "_accepted"}, bus.o_ready, 1);
    @(posedge i_clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic bin, input logic [31:0] ed, input logic eb,
                          input logic ez, input logic en, input logic eo);
    bus.i_ready = 1'b1;
    send(a, b, bin, tag);
    bus.i_valid = 1'b0;
    check({tag, "_lat1"}, bus.o_valid, 0);
    @(posedge i_clk);
    #1;
    check({tag, "_lat2"}, bus.o_valid, 1);
    check({tag, "_d"}, bus.o_d, ed);
    check({tag, "_flags"}, {bus.o_borrow, bus.o_zero, bus.o_neg, bus.o_ovf}, {eb, ez, en, eo});
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc0;
    int cyc;
    logic [31:0] ra;

    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_bin   = 1'b0;
    bus.i_ready = 1'b0;
    i_rstn      = 1'b0;

    // Reset state
    #12;
    check("rst_valid", bus.o_valid, 0);
    check("rst_ready", bus.o_ready, 1);
    check("rst_d", bus.o_d, 0);
    check("rst_flags", {bus.o_borrow, bus.o_zero, bus.o_neg, bus.o_ovf}, 0);
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed arithmetic corners
    directed("basic",   32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 0, 0, 0, 0);
    directed("wrap",    32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1, 0, 1, 0);
    directed("split",   32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 0, 0, 0, 0);
    directed("ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 0, 0, 0, 1);
    directed("eq_bin",  32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1, 0, 1, 0);
    directed("eq_zero", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 0, 1, 0, 0);

    // Backpressure: 4 vectors with the consumer stalled
    bus.i_ready = 1'b0;
    send(32'h0000_0100, 32'h0000_0001, 1'b0, "bp0");
    send(32'h0000_0200, 32'h0000_0002, 1'b1, "bp1");
    check("bp_full_ready", bus.o_ready, 0);
    bus.i_a = 32'h0000_0300;
    bus.i_b = 32'h0000_0003;
    repeat (3) begin
      @(posedge i_clk);
      #1;
      check("bp_stalled_ready", bus.o_ready, 0);
    end
    bus.i_ready = 1'b1;
    send(32'h0000_0300, 32'h0000_0003, 1'b0, "bp2");
    send(32'h0000_0400, 32'h0000_0004, 1'b1, "bp3");
    bus.i_valid = 1'b0;
    repeat (4) begin
      @(posedge i_clk);
      #1;
    end
    check("bp_drained", exp_q.size(), 0);

    // Reset mid-stream with a full pipeline
    bus.i_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, "rs0");
    send(32'hCAFE_F00D, 32'h0000_2222, 1'b1, "rs1");
    bus.i_valid = 1'b0;
    i_rstn = 1'b0;
    #1;
    check("midrst_valid", bus.o_valid, 0);
    check("midrst_d", bus.o_d, 0);
    check("midrst_ready", bus.o_ready, 1);
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    bus.i_ready = 1'b1;
    repeat (4) begin
      @(posedge i_clk);
      #1;
      check("no_stale_valid", bus.o_valid, 0);
    end

    // Random traffic
    acc0 = n_acc;
    cyc  = 0;
    while ((n_acc - acc0) < 10000 && cyc < 50000) begin
      bus.i_valid = ($urandom_range(0, 3) != 0);
      ra          = rand_operand();
      bus.i_a     = ra;
      bus.i_b     = ($urandom_range(0, 7) == 0) ? ra : rand_operand();
      bus.i_bin   = $urandom_range(0, 1) == 1;
      bus.i_ready = ($urandom_range(0, 3) != 0);
      @(posedge i_clk);
      #1;
      cyc++;
    end
    check("random_count", ((n_acc - acc0) >= 10000), 1);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (4) begin
      @(posedge i_clk);
      #1;
    end
    check("random_drained", exp_q.size(), 0);
    check("final_idle", bus.o_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
